// File: rtl/ctr_pr_timer_pkg.sv
// Shared definitions for the pseudorandom interval timer: LFSR tap masks,
// the single-step helper used by the core and the compare path, and FSM encoding.
package ctr_pr_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } pr_state_e;

  // Tap bit mask per legal width; bit i set means q[i] feeds the XNOR.
  function automatic logic [7:0] pr_taps(input int n);
    case (n)
      4:       return 8'h0C;
      5:       return 8'h14;
      7:       return 8'h60;
      8:       return 8'hB8;
      default: return 8'h00;
    endcase
  endfunction

  // One Fibonacci XNOR shift-left step, result confined to the low n bits.
  function automatic logic [7:0] pr_step(input logic [7:0] q, input int n);
    logic [7:0] m;
    m = 8'hFF >> (8 - n);
    return {q[6:0], ~^(q & pr_taps(n))} & m;
  endfunction

endpackage

// File: rtl/ctr_pr_timer_if.sv
// Configuration / control / status bundle of the pseudorandom interval timer.
interface ctr_pr_timer_if #(parameter int N = 5);
  logic [N-1:0] cfg_period;
  logic         cfg_mode;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         start;
  logic         stop;
  logic         inc;
  logic         tick;
  logic         busy;
  logic         cal_ok;
  logic [N-1:0] out;

  modport master (
    output cfg_period, cfg_mode, cfg_valid, start, stop, inc,
    input  cfg_ready, tick, busy, cal_ok, out
  );

  modport slave (
    input  cfg_period, cfg_mode, cfg_valid, start, stop, inc,
    output cfg_ready, tick, busy, cal_ok, out
  );
endinterface

// File: rtl/ctr_pr_core.sv
// N-bit XNOR LFSR seeded at zero; clear wins over step.
module ctr_pr_core
  import ctr_pr_timer_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         clr,
  output logic [N-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out <= '0;
    else if (clr)  out <= '0;
    else if (step) out <= N'(pr_step(8'(out), N));
  end

endmodule

// File: rtl/ctr_pr_timer.sv
// Programmable interval timer: the binary period is converted once into an
// LFSR terminal state, so the run path only needs an N-bit equality compare.
module ctr_pr_timer
  import ctr_pr_timer_pkg::*;
#(
  parameter int N = 5
) (
  input  logic            clk,
  input  logic            rst,
  ctr_pr_timer_if.slave   bus
);

  localparam logic [N-1:0] P_MAX = '1;

  pr_state_e    state;
  logic [N-1:0] cnt, term, q, q_nxt;
  logic         mode, cal_ok, tick, busy, cfg_ready;
  logic         cfg_hs, run_go, cal_done, run_stop, hit, core_step, core_clr;

  assign q_nxt    = N'(pr_step(8'(q), N));
  assign cfg_hs   = (state == ST_IDLE) & bus.cfg_valid;
  assign run_go   = (state == ST_IDLE) & bus.start & cal_ok & ~bus.cfg_valid;
  assign cal_done = (state == ST_CAL) & (cnt == '0);
  assign run_stop = (state == ST_RUN) & bus.stop;
  // stop outranks a terminal hit on the same edge
  assign hit      = (state == ST_RUN) & ~bus.stop & bus.inc & (q_nxt == term);

  assign core_clr  = cfg_hs | run_go | cal_done | run_stop | hit;
  assign core_step = ((state == ST_CAL) & (cnt != '0)) | ((state == ST_RUN) & bus.inc);

  ctr_pr_core #(.N(N)) u_core (
    .clk  (clk),
    .rst  (rst),
    .step (core_step),
    .clr  (core_clr),
    .out  (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      term      <= '0;
      mode      <= 1'b0;
      cal_ok    <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      tick <= hit;
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            mode      <= bus.cfg_mode;
            cnt       <= (bus.cfg_period == '0) ? P_MAX : bus.cfg_period;
            cal_ok    <= 1'b0;
            state     <= ST_CAL;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end else if (run_go) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        ST_CAL: begin
          if (cal_done) begin
            term      <= q;
            cal_ok    <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            cnt <= cnt - N'(1);
          end
        end
        ST_RUN: begin
          if (run_stop || (hit && !mode)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tick      = tick;
  assign bus.busy      = busy;
  assign bus.cal_ok    = cal_ok;
  assign bus.cfg_ready = cfg_ready;
  assign bus.out       = q;

endmodule

// File: tb/tb_ctr_pr_timer.sv
// Bench for ctr_pr_timer at N=4,5,7: directed scenarios plus random traffic,
// every cycle compared against a position-counting reference model.
module tb_ctr_pr_timer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctr_pr_timer_if #(.N(4)) b4 ();
  ctr_pr_timer_if #(.N(5)) b5 ();
  ctr_pr_timer_if #(.N(7)) b7 ();

  ctr_pr_timer #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  ctr_pr_timer #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(b5));
  ctr_pr_timer #(.N(7)) u7 (.clk(clk), .rst(rst), .bus(b7));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nw(input int w);
    return (w == 0) ? 4 : (w == 1) ? 5 : 7;
  endfunction

  // Model: seq[w][k] is the LFSR state k steps after zero; the DUT state is
  // tracked as a position count along that sequence, never as a terminal compare.
  logic [7:0] seq [3][128];
  int  ms [3];    // 0 idle, 1 calibrating, 2 running
  int  mpos [3];
  int  mP [3];
  int  mcc [3];
  int  ticks [3];
  bit  mmode [3];
  bit  mcal [3];
  bit  mtick [3];
  int  bcnt;

  logic [7:0] lo;
  bit lt, lb, lr, lc;

  function automatic void build_seq();
    for (int w = 0; w < 3; w++) begin
      logic [7:0] q, tm, msk;
      tm  = (w == 0) ? 8'h0C : (w == 1) ? 8'h14 : 8'h60;   // taps 3,2 / 4,2 / 6,5
      msk = 8'((1 << nw(w)) - 1);
      q = 8'h00;
      seq[w][0] = q;
      for (int k = 1; k < 128; k++) begin
        q = {q[6:0], ~^(q & tm)} & msk;
        seq[w][k] = q;
      end
    end
  endfunction

  function automatic void mrst();
    for (int w = 0; w < 3; w++) begin
      ms[w] = 0; mpos[w] = 0; mcal[w] = 0; mtick[w] = 0; mmode[w] = 0; mcc[w] = 0; mP[w] = 1;
    end
  endfunction

  task automatic rd(input int w);
    case (w)
      0: begin lo = 8'(b4.out); lt = b4.tick; lb = b4.busy; lr = b4.cfg_ready; lc = b4.cal_ok; end
      1: begin lo = 8'(b5.out); lt = b5.tick; lb = b5.busy; lr = b5.cfg_ready; lc = b5.cal_ok; end
      default: begin lo = 8'(b7.out); lt = b7.tick; lb = b7.busy; lr = b7.cfg_ready; lc = b7.cal_ok; end
    endcase
  endtask

  task automatic drv(input int w, input bit v, input int per, input bit md,
                     input bit st, input bit sp, input bit in);
    case (w)
      0: begin b4.cfg_valid = v; b4.cfg_period = 4'(per); b4.cfg_mode = md;
               b4.start = st; b4.stop = sp; b4.inc = in; end
      1: begin b5.cfg_valid = v; b5.cfg_period = 5'(per); b5.cfg_mode = md;
               b5.start = st; b5.stop = sp; b5.inc = in; end
      default: begin b7.cfg_valid = v; b7.cfg_period = 7'(per); b7.cfg_mode = md;
               b7.start = st; b7.stop = sp; b7.inc = in; end
    endcase
  endtask

  // Check outputs at the falling edge, then drive inputs for the next rising
  // edge and advance the model across that edge.
  task automatic cyc(input int w, input bit v, input int per, input bit md,
                     input bit st, input bit sp, input bit in);
    int L;
    L = (1 << nw(w)) - 1;
    @(negedge clk);
    rd(w);
    chk($sformatf("w%0d out", w),    32'(lo), 32'(seq[w][mpos[w]]));
    chk($sformatf("w%0d tick", w),   32'(lt), 32'(mtick[w]));
    chk($sformatf("w%0d busy", w),   32'(lb), 32'(ms[w] != 0));
    chk($sformatf("w%0d rdy", w),    32'(lr), 32'(ms[w] == 0));
    chk($sformatf("w%0d cal_ok", w), 32'(lc), 32'(mcal[w]));
    ticks[w] += int'(lt);
    if (lb) bcnt++;
    drv(w, v, per, md, st, sp, in);
    mtick[w] = 0;
    case (ms[w])
      0: begin
        if (v) begin
          mP[w] = (per == 0) ? L : per;
          mmode[w] = md; mpos[w] = 0; mcc[w] = 0; mcal[w] = 0; ms[w] = 1;
        end else if (st && mcal[w]) begin
          mpos[w] = 0; ms[w] = 2;
        end
      end
      1: begin
        if (mcc[w] < mP[w]) begin mcc[w]++; mpos[w]++; end
        else begin mpos[w] = 0; mcal[w] = 1; ms[w] = 0; end
      end
      default: begin
        if (sp) begin
          mpos[w] = 0; ms[w] = 0;
        end else if (in) begin
          mpos[w]++;
          if (mpos[w] == mP[w]) begin
            mpos[w] = 0; mtick[w] = 1;
            if (!mmode[w]) ms[w] = 0;
          end
        end
      end
    endcase
  endtask

  task automatic idle(input int w);
    cyc(w, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic inc1(input int w);
    cyc(w, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 3; w++) drv(w, 0, 0, 0, 0, 0, 0);
    build_seq();
    mrst();
    #1;
    rd(0);
    chk("rst out", 32'(lo), 0);
    chk("rst busy", 32'(lb), 0);
    chk("rst rdy", 32'(lr), 1);
    chk("rst tick", 32'(lt), 0);
    #12 rst = 1'b0;

    // asynchronous reset in the middle of a calibration
    cyc(0, 1, 10, 0, 0, 0, 0);
    repeat (4) idle(0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    rd(0);
    chk("arst out", 32'(lo), 0);
    chk("arst cal_ok", 32'(lc), 0);
    chk("arst busy", 32'(lb), 0);
    chk("arst rdy", 32'(lr), 1);
    mrst();
    #1 rst = 1'b0;

    // calibration N=4 P=5, periodic
    cyc(0, 1, 5, 1, 0, 0, 0);
    bcnt = 0;
    repeat (6) idle(0);
    chk("w0 term state", 32'(lo), 32'hD);
    idle(0);
    chk("w0 cal busy cycles", 32'(bcnt), 6);
    chk("w0 cal_ok", 32'(lc), 1);

    // periodic run, inc held for 20 cycles
    ticks[0] = 0;
    cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (20) inc1(0);
    idle(0);
    chk("w0 periodic ticks", 32'(ticks[0]), 4);
    chk("w0 wrap out", 32'(lo), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // stop on the cycle of the 5th inc, then a clean restart
    ticks[0] = 0;
    cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (4) inc1(0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle(0);
    chk("w0 stop ticks", 32'(ticks[0]), 0);
    chk("w0 stop out", 32'(lo), 0);
    chk("w0 stop busy", 32'(lb), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    repeat (5) inc1(0);
    idle(0);
    chk("w0 restart ticks", 32'(ticks[0]), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // one-shot N=5 P=3 with gapped inc
    cyc(1, 1, 3, 0, 0, 0, 0);
    repeat (5) idle(1);
    ticks[1] = 0;
    cyc(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0, (i % 2) == 0);
    chk("w1 oneshot ticks", 32'(ticks[1]), 1);
    chk("w1 oneshot busy", 32'(lb), 0);
    repeat (6) inc1(1);
    chk("w1 idle ticks", 32'(ticks[1]), 1);

    // N=7 full-length period
    cyc(2, 1, 0, 1, 0, 0, 0);
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      idle(2);
      if (!lb) break;
    end
    chk("w2 cal cycles", 32'(bcnt), 128);
    ticks[2] = 0;
    cyc(2, 0, 0, 0, 1, 0, 0);
    repeat (254) inc1(2);
    idle(2);
    chk("w2 full ticks", 32'(ticks[2]), 2);
    cyc(2, 0, 0, 0, 0, 1, 0);

    // P=1 ticks every inc; cfg offered during RUN is refused
    cyc(2, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle(2);
    ticks[2] = 0;
    cyc(2, 0, 0, 0, 1, 0, 0);
    repeat (10) inc1(2);
    cyc(2, 1, 3, 0, 0, 0, 1);
    chk("w2 rdy in run", 32'(lr), 0);
    idle(2);
    chk("w2 p1 ticks", 32'(ticks[2]), 11);
    cyc(2, 0, 0, 0, 0, 1, 0);

    // random traffic on every width
    for (int w = 0; w < 3; w++) begin
      int L;
      L = (1 << nw(w)) - 1;
      repeat (500)
        cyc(w, $urandom_range(0, 15) == 0, int'($urandom_range(0, L)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ctr_pr_timer.md
Name: ctr_pr_timer

Overview:
Programmable interval timer built on a pseudorandom (LFSR) counter.
- A binary period is loaded through a valid/ready handshake.
- A calibration phase converts the period into the LFSR terminal state.
- In run mode, each `inc` advances the LFSR and the block pulses `tick` every PERIOD increments, one-shot or periodic.
- The cheap N-bit equality compare keeps the run path fast for iCE40 timing; the binary-to-LFSR conversion is paid once per configuration.

Parameters:
- N, 5, counter width; legal values 4, 5, 7, 8. Sequence length is 2^N-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cfg_period  in  N  period in inc events, binary; 0 means 2^N-1
- cfg_mode  in  1  0 = one-shot, 1 = periodic
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- start  in  1  begin counting (single-cycle pulse)
- stop  in  1  abort counting (single-cycle pulse)
- inc  in  1  count enable; one LFSR step per cycle when high in RUN
- tick  out  1  one-cycle pulse on period completion
- busy  out  1  high in CAL or RUN
- cal_ok  out  1  a valid calibration is held
- out  out  N  current LFSR state

Behaviour:

LFSR (ctr_pr_core):
- Fibonacci XNOR, shift left: `q <= {q[N-2:0], ~(q[a]^q[b]...)}`.
- Taps:
  - N=4: 3,2
  - N=5: 4,2
  - N=7: 6,5
  - N=8: 7,5,4,3
- Seed is 0. The all-ones state is never reached.

Reset:
- state = IDLE
- out = 0, term = 0, mode = 0
- tick = 0, busy = 0, cal_ok = 0
- cfg_ready = 1
- A reset in any state, including mid-CAL or mid-RUN, discards the calibration.

FSM states: IDLE, CAL, RUN.

IDLE:
- cfg_ready = 1.
- Handshake: cfg_valid & cfg_ready at an edge:
  - latch mode;
  - load binary down-counter with P (P = 2^N-1 if cfg_period = 0);
  - LFSR cleared to 0;
  - cal_ok = 0;
  - go to CAL.
- start with cal_ok = 1 and no simultaneous cfg handshake:
  - LFSR cleared to 0;
  - go to RUN.
- start with cal_ok = 0: ignored.
- cfg handshake and start in the same cycle: cfg wins, start is ignored.
- stop: ignored.

CAL:
- cfg_ready = 0, busy = 1.
- Each cycle: LFSR steps and the down-counter decrements; inc is ignored.
- When the counter reaches 0 (after exactly P steps):
  - term <= LFSR state after P steps;
  - LFSR cleared to 0;
  - cal_ok = 1;
  - go to IDLE.
- Duration: P cycles, plus 1 cycle for the capture and clear.
- start and stop during CAL: ignored.

RUN:
- busy = 1, cfg_ready = 0.
- On each edge with inc = 1, the LFSR steps.
- If the next state equals term:
  - tick = 1 in the following cycle (registered, exactly 1 cycle);
  - periodic: LFSR reloads 0 at that edge, stay in RUN;
  - one-shot: LFSR reloads 0, go to IDLE.
- stop at an edge: go to IDLE, LFSR cleared to 0, no tick. This holds even if inc would hit term in the same cycle (stop has priority). cal_ok is kept.
- start in RUN: ignored. No restart is performed.

Period behaviour:
- P = 2^N-1: term = 0, giving a full-sequence wrap.
- P = 1: a tick on every inc.

tick:
- Never asserted outside RUN, except for the registered pulse in the cycle after the final edge.
- Never asserted for 2 consecutive cycles unless P = 1 with inc held high.

Decomposition:
- Shared include (alongside the existing counter library):
  - LFSR tap masks per N as localparams/function `pr_taps(N)`;
  - FSM state encoding constants.
- Sub-module ctr_pr_core:
  - ports: clk, rst, step, clr, out;
  - clr has priority over step;
  - instantiated once; used by both CAL and RUN.
- Binary down-counter, term register and FSM live in ctr_pr_timer.

Test Plan:
1. Reset values: assert rst mid-CAL (N=4, P=10, after 4 cycles) -> out = 0, cal_ok = 0, busy = 0, cfg_ready = 1 immediately, without waiting for a clock.
2. Calibration: N=4, cfg_period = 5 -> busy for 6 cycles, then cal_ok = 1 and term = 4'b1101. Expected sequence: 0000, 0001, 0011, 0111, 1110, 1101.
3. Periodic run: N=4, P=5, mode = 1, start, inc held high for 20 cycles -> tick pulses exactly 4 times at 5-cycle spacing; out returns to 0000 after each pulse.
4. One-shot with gapped inc: N=5, P=3, mode = 0, inc high on alternate cycles -> a single tick after the 3rd inc edge; then IDLE, busy = 0, later incs produce no tick.
5. Stop priority: N=4, P=5, stop asserted on the cycle of the 5th inc -> no tick, IDLE, out = 0; a following start plus 5 incs -> tick.
6. Boundary periods: N=7, cfg_period = 0 -> calibration 128 cycles, term = 0, one tick per 127 incs. cfg_period = 1 with inc held high -> tick every cycle. A cfg_valid offered during RUN is not accepted (cfg_ready = 0).
